mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access and writeback stage of the pipelined RV32I core. Takes the EX/MEM bundle,
//  performs loads/stores over a req/ack data-memory handshake, stalls upstream while memory
//  is busy, and registers the MEM/WB result. It is the writer of the register-file write port
//  (RegWriteWB/writeRegAddr/WD3) that the decode stage consumes.
// PARAMETERS
//  XLEN        32  datapath width; only 32 supported
//  ZERO_GUARD  1   1 = suppress writeback when rd==x0
// PORTS
//  clk_i           in   1   clock, all state on rising edge
//  rst_ni          in   1   asynchronous active-low reset
//  valid_i         in   1   EX/MEM slot holds a live instruction
//  RegWrite_i      in   1   instruction writes rd
//  WriteSrc_i      in   2   00 ALU result, 01 load data, 10 pcPlus4, 11 ImmOp
//  MemWrite_i      in   1   store
//  funct3_i        in   3   access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//  rd_i            in   5   destination register
//  ALUResult_i     in   32  ALU result / effective address
//  regOp2_i        in   32  store data
//  pcPlus4_i       in   32  link value for jal/jalr
//  ImmOp_i         in   32  immediate for lui
//  stall_o         out  1   upstream must hold EX/MEM contents this cycle
//  misalign_o      out  1   1-cycle pulse: misaligned access dropped
//  dmem_req_o      out  1   memory request valid
//  dmem_we_o       out  1   1 store, 0 load
//  dmem_addr_o     out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be_o       out  4   byte enables
//  dmem_wdata_o    out  32  lane-replicated store data
//  dmem_ack_i      in   1   request accepted/completed this cycle (load data valid)
//  dmem_rdata_i    in   32  load data, valid with ack
//  RegWriteWB_o    out  1   register-file write enable to decode stage
//  writeRegAddr_o  out  5   register-file write address
//  WD3_o           out  32  register-file write data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; MEM/WB register cleared (no write).
//  - mem = valid_i & (MemWrite_i | WriteSrc_i==01). Misaligned: h with addr[0]=1, w with addr[1:0]!=0.
//  - FSM IDLE: mem & aligned -> dmem_req_o=1 combinationally from inputs. ack same cycle ->
//    complete, stall_o=0. No ack -> stall_o=1, capture addr/be/wdata/we/funct3/rd/byte-offset,
//    go WAIT.
//  - WAIT: dmem_req_o=1 with captured fields (stable regardless of inputs); stall_o=!dmem_ack_i;
//    on ack -> complete, IDLE. No timeout.
//  - Misaligned: no request, no stall, misalign_o=1 that cycle, instruction retires with no write.
//  - Store lanes: sb be=1<<a[1:0], wdata={4{b}}; sh be=a[1]?1100:0011, wdata={2{h}}; sw be=1111.
//  - Load extract: select byte/half by offset; b/h sign-extend, bu/hu zero-extend; other funct3=word.
//  - Result mux: 00 ALUResult, 01 extracted load, 10 pcPlus4, 11 ImmOp.
//  - MEM/WB register (1-cycle latency): on edge where instruction completes (non-mem: valid_i&
//    !stall_o; mem: ack), load RegWriteWB=RegWrite_i & !misaligned & !(ZERO_GUARD & rd==0),
//    addr, data. Stores/branches write nothing. Otherwise (stall or !valid_i) load a bubble: RegWriteWB=0.
//  - dmem_ack_i while no request outstanding: ignored.
//  - Reset mid-WAIT: req drops immediately, state IDLE, pending access discarded.
// TESTING
//  1 rst_ni=0 with random inputs -> all outputs 0; release -> RegWriteWB_o stays 0 while valid_i=0.
//  2 valid, RegWrite, WriteSrc=00, rd=5, ALUResult=0x1234 -> next cycle RegWriteWB=1, addr 5, WD3=0x1234.
//  3 lb addr 0x103, ack after 3 cycles, rdata=0x80000000 -> stall_o 3 cycles, req/addr 0x100 held
//    stable, next cycle after ack WD3=0xFFFFFF80; same with lbu -> 0x00000080.
//  4 sh addr 0x102 data 0x0000ABCD, ack same cycle -> be=1100, wdata=0xABCDABCD, no stall, no write.
//  5 lw addr 0x101 -> no req, misalign_o pulse, RegWriteWB=0; jal rd=1 WriteSrc=10 pcPlus4=0x48 -> WD3=0x48.
//  6 rd=0 ALU write -> RegWriteWB=0; assert rst_ni low during WAIT -> req_o falls same cycle, late ack ignored.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master) and the memory (slave).
interface mem_wb_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: issues loads/stores over a req/ack handshake,
// stalls upstream while memory is busy, and registers the register-file write port.
module mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter bit ZERO_GUARD = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic [1:0]        WriteSrc_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_i,
    input  logic [XLEN-1:0]   ALUResult_i,
    input  logic [XLEN-1:0]   regOp2_i,
    input  logic [XLEN-1:0]   pcPlus4_i,
    input  logic [XLEN-1:0]   ImmOp_i,
    output logic              stall_o,
    output logic              misalign_o,
    mem_wb_stage_if.master    dmem,
    output logic              RegWriteWB_o,
    output logic [4:0]        writeRegAddr_o,
    output logic [XLEN-1:0]   WD3_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [3:0]      cap_be;
    logic            cap_we;
    logic            cap_reg_write;
    logic [2:0]      cap_funct3;
    logic [4:0]      cap_rd;
    logic [1:0]      cap_off;

    logic            is_mem;
    logic            misaligned;
    logic            issue;
    logic            req;
    logic [3:0]      in_be;
    logic [XLEN-1:0] in_wdata;
    logic            wb_en_next;
    logic [4:0]      wb_addr_next;
    logic [XLEN-1:0] wb_data_next;

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                    input logic [2:0]      f3,
                                                    input logic [1:0]      off);
        logic [XLEN-1:0] shifted;
        logic [15:0]     half;
        shifted = word >> {off, 3'b000};
        half    = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  return {24'd0, shifted[7:0]};
            3'b001:  return {{16{half[15]}}, half};
            3'b101:  return {16'd0, half};
            default: return word;
        endcase
    endfunction

    assign is_mem     = valid_i & (MemWrite_i | (WriteSrc_i == 2'b01));
    assign misaligned = is_mem & (((funct3_i[1:0] == 2'b01) & ALUResult_i[0]) |
                                  ((funct3_i[1:0] == 2'b10) & (ALUResult_i[1:0] != 2'b00)));
    assign issue      = (state == IDLE) & is_mem & ~misaligned;

    // Gating with rst_ni keeps every output low while reset is held, even mid-transaction.
    assign req        = rst_ni & ((state == WAIT) | issue);
    assign stall_o    = req & ~dmem.ack;
    assign misalign_o = rst_ni & (state == IDLE) & misaligned;

    always_comb begin
        in_be    = 4'b0000;
        in_wdata = '0;
        case (funct3_i[1:0])
            2'b00: begin
                in_be    = 4'b0001 << ALUResult_i[1:0];
                in_wdata = {4{regOp2_i[7:0]}};
            end
            2'b01: begin
                in_be    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{regOp2_i[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = regOp2_i;
            end
        endcase
    end

    always_comb begin
        dmem.req   = req;
        dmem.we    = 1'b0;
        dmem.addr  = '0;
        dmem.be    = 4'b0000;
        dmem.wdata = '0;
        if (req) begin
            if (state == WAIT) begin
                dmem.we    = cap_we;
                dmem.addr  = cap_addr;
                dmem.be    = cap_be;
                dmem.wdata = cap_wdata;
            end else begin
                dmem.we    = MemWrite_i;
                dmem.addr  = {ALUResult_i[XLEN-1:2], 2'b00};
                dmem.be    = in_be;
                dmem.wdata = in_wdata;
            end
        end
    end

    // Stores never write rd; anything not completing this cycle becomes a bubble.
    always_comb begin
        wb_en_next   = 1'b0;
        wb_addr_next = '0;
        wb_data_next = '0;
        if (state == WAIT) begin
            if (dmem.ack) begin
                wb_en_next   = cap_reg_write & ~cap_we & ~(ZERO_GUARD && (cap_rd == 5'd0));
                wb_addr_next = cap_rd;
                wb_data_next = load_extract(dmem.rdata, cap_funct3, cap_off);
            end
        end else if (valid_i & ~(issue & ~dmem.ack)) begin
            wb_en_next   = RegWrite_i & ~misaligned & ~(is_mem & MemWrite_i) &
                           ~(ZERO_GUARD && (rd_i == 5'd0));
            wb_addr_next = rd_i;
            case (WriteSrc_i)
                2'b00:   wb_data_next = ALUResult_i;
                2'b01:   wb_data_next = load_extract(dmem.rdata, funct3_i, ALUResult_i[1:0]);
                2'b10:   wb_data_next = pcPlus4_i;
                default: wb_data_next = ImmOp_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cap_addr      <= '0;
            cap_wdata     <= '0;
            cap_be        <= 4'b0000;
            cap_we        <= 1'b0;
            cap_reg_write <= 1'b0;
            cap_funct3    <= 3'b000;
            cap_rd        <= 5'd0;
            cap_off       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && !dmem.ack) begin
                        state         <= WAIT;
                        cap_addr      <= {ALUResult_i[XLEN-1:2], 2'b00};
                        cap_wdata     <= in_wdata;
                        cap_be        <= in_be;
                        cap_we        <= MemWrite_i;
                        cap_reg_write <= RegWrite_i;
                        cap_funct3    <= funct3_i;
                        cap_rd        <= rd_i;
                        cap_off       <= ALUResult_i[1:0];
                    end
                end
                default: begin
                    if (dmem.ack) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            RegWriteWB_o   <= 1'b0;
            writeRegAddr_o <= 5'd0;
            WD3_o          <= '0;
        end else begin
            RegWriteWB_o   <= wb_en_next;
            writeRegAddr_o <= wb_addr_next;
            WD3_o          <= wb_data_next;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a byte-addressed memory model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, RegWrite_i, MemWrite_i;
    logic [1:0]  WriteSrc_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] ALUResult_i, regOp2_i, pcPlus4_i, ImmOp_i;
    logic        stall_o, misalign_o, RegWriteWB_o;
    logic [4:0]  writeRegAddr_o;
    logic [31:0] WD3_o;

    logic [7:0]  mem_bytes [0:255];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.XLEN(32)) dmem_bus ();

    mem_wb_stage #(.XLEN(32), .ZERO_GUARD(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .WriteSrc_i(WriteSrc_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .rd_i(rd_i),
        .ALUResult_i(ALUResult_i), .regOp2_i(regOp2_i), .pcPlus4_i(pcPlus4_i), .ImmOp_i(ImmOp_i),
        .stall_o(stall_o), .misalign_o(misalign_o), .dmem(dmem_bus.master),
        .RegWriteWB_o(RegWriteWB_o), .writeRegAddr_o(writeRegAddr_o), .WD3_o(WD3_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [7:0] w;
        w = a & 8'hFC;
        return {mem_bytes[w + 8'd3], mem_bytes[w + 8'd2], mem_bytes[w + 8'd1], mem_bytes[w]};
    endfunction

    // Drives one EX/MEM instruction starting at a falling edge, plays memory with the
    // given ack latency, and checks the handshake and the following writeback.
    task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] ws,
                                 input logic mw, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] op2,
                                 input logic [31:0] pc4, input logic [31:0] imm, input int lat);
        logic        is_mem, mis, exp_en;
        int          size, off;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_load, exp_data;
        valid_i = v; RegWrite_i = rw; WriteSrc_i = ws; MemWrite_i = mw; funct3_i = f3;
        rd_i = rd; ALUResult_i = alu; regOp2_i = op2; pcPlus4_i = pc4; ImmOp_i = imm;

        is_mem = v && (mw || ws == 2'b01);
        size   = (f3 == 3'b010) ? 4 : ((f3 == 3'b001 || f3 == 3'b101) ? 2 : 1);
        off    = int'(alu[1:0]);
        mis    = is_mem && ((off % size) != 0);
        exp_be = 4'((1 << size) - 1) << off;
        exp_wd = '0;
        for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = op2[8*(k % size) +: 8];
        exp_load = '0;
        for (int i = 0; i < size; i++) exp_load |= 32'(mem_bytes[alu[7:0] + 8'(i)]) << (8*i);
        if (!f3[2] && size == 1 && exp_load[7])  exp_load |= 32'hFFFF_FF00;
        if (!f3[2] && size == 2 && exp_load[15]) exp_load |= 32'hFFFF_0000;
        case (ws)
            2'b00:   exp_data = alu;
            2'b01:   exp_data = exp_load;
            2'b10:   exp_data = pc4;
            default: exp_data = imm;
        endcase
        exp_en = v && rw && !mis && !(is_mem && mw) && rd != 5'd0;

        if (is_mem && !mis) begin
            for (int k = 0; k <= lat; k++) begin
                if (k > 0) begin
                    ALUResult_i = $urandom; regOp2_i = $urandom; rd_i = 5'($urandom);
                end
                dmem_bus.ack   = (k == lat);
                dmem_bus.rdata = mem_word(alu[7:0]);
                #1;
                checkOutput("req", dmem_bus.req, 1'b1);
                checkOutput("addr", dmem_bus.addr, alu & 32'hFFFF_FFFC);
                checkOutput("we", dmem_bus.we, mw);
                checkOutput("stall", stall_o, k < lat);
                if (mw) begin
                    checkOutput("be", dmem_bus.be, exp_be);
                    checkOutput("wdata", dmem_bus.wdata, exp_wd);
                end
                @(posedge clk);
                @(negedge clk);
            end
            if (mw) for (int i = 0; i < size; i++) mem_bytes[alu[7:0] + 8'(i)] = op2[8*i +: 8];
        end else begin
            dmem_bus.ack   = 1'($urandom);
            dmem_bus.rdata = $urandom;
            #1;
            checkOutput("req_idle", dmem_bus.req, 1'b0);
            checkOutput("stall_idle", stall_o, 1'b0);
            checkOutput("misalign", misalign_o, mis);
            @(posedge clk);
            @(negedge clk);
        end
        dmem_bus.ack = 1'b0;
        checkOutput("wb_en", RegWriteWB_o, exp_en);
        if (exp_en) begin
            checkOutput("wb_addr", writeRegAddr_o, rd);
            checkOutput("wb_data", WD3_o, exp_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);
        rst_n = 1'b0;
        valid_i = 1'b1; RegWrite_i = 1'b1; WriteSrc_i = 2'b01; MemWrite_i = 1'b1;
        funct3_i = 3'b010; rd_i = 5'd9; ALUResult_i = 32'h100; regOp2_i = $urandom;
        pcPlus4_i = $urandom; ImmOp_i = $urandom;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = $urandom;
        #2;
        checkOutput("rst_req", dmem_bus.req, 1'b0);
        checkOutput("rst_stall", stall_o, 1'b0);
        checkOutput("rst_misalign", misalign_o, 1'b0);
        checkOutput("rst_addr", dmem_bus.addr, 32'h0);
        checkOutput("rst_be", dmem_bus.be, 4'h0);
        checkOutput("rst_wdata", dmem_bus.wdata, 32'h0);
        checkOutput("rst_we", dmem_bus.we, 1'b0);
        @(negedge clk);
        checkOutput("rst_wb_en", RegWriteWB_o, 1'b0);
        checkOutput("rst_wb_addr", writeRegAddr_o, 5'd0);
        checkOutput("rst_wd3", WD3_o, 32'h0);
        valid_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("idle_wb_en", RegWriteWB_o, 1'b0);
        end

        applyStimulus(1, 1, 2'b00, 0, 3'b010, 5'd5, 32'h1234, 0, 0, 0, 0);
        checkOutput("alu_wd3", WD3_o, 32'h0000_1234);

        mem_bytes[0] = 8'h00; mem_bytes[1] = 8'h00; mem_bytes[2] = 8'h00; mem_bytes[3] = 8'h80;
        applyStimulus(1, 1, 2'b01, 0, 3'b000, 5'd7, 32'h103, 0, 0, 0, 3);
        checkOutput("lb_wd3", WD3_o, 32'hFFFF_FF80);
        applyStimulus(1, 1, 2'b01, 0, 3'b100, 5'd7, 32'h103, 0, 0, 0, 3);
        checkOutput("lbu_wd3", WD3_o, 32'h0000_0080);

        applyStimulus(1, 0, 2'b00, 1, 3'b001, 5'd0, 32'h102, 32'h0000_ABCD, 0, 0, 0);
        applyStimulus(1, 1, 2'b01, 0, 3'b101, 5'd8, 32'h102, 0, 0, 0, 1);
        checkOutput("lhu_readback", WD3_o, 32'h0000_ABCD);

        applyStimulus(1, 1, 2'b01, 0, 3'b010, 5'd3, 32'h101, 0, 0, 0, 0);
        applyStimulus(1, 1, 2'b10, 0, 3'b000, 5'd1, $urandom, 0, 32'h48, 0, 0);
        checkOutput("jal_wd3", WD3_o, 32'h0000_0048);
        applyStimulus(1, 1, 2'b00, 0, 3'b000, 5'd0, 32'hDEAD, 0, 0, 0, 0);

        // Reset while a load is outstanding, then a stray ack after release.
        valid_i = 1'b1; RegWrite_i = 1'b1; WriteSrc_i = 2'b01; MemWrite_i = 1'b0;
        funct3_i = 3'b010; rd_i = 5'd4; ALUResult_i = 32'h104; dmem_bus.ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("wait_req", dmem_bus.req, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wait_req", dmem_bus.req, 1'b0);
        checkOutput("rst_wait_stall", stall_o, 1'b0);
        @(negedge clk);
        valid_i = 1'b0; dmem_bus.ack = 1'b1; rst_n = 1'b1;
        #1;
        checkOutput("late_ack_req", dmem_bus.req, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("late_ack_wb", RegWriteWB_o, 1'b0);
        dmem_bus.ack = 1'b0;

        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [2:0]  f3;
            logic [31:0] addr;
            kind = $urandom_range(0, 5);
            addr = 32'h100 | 32'($urandom_range(0, 255));
            case (kind)
                0: applyStimulus(1, 1, 2'b00, 0, 3'($urandom), 5'($urandom), $urandom,
                                 $urandom, $urandom, $urandom, 0);
                1: applyStimulus(1, 1, 2'b11, 0, 3'($urandom), 5'($urandom), $urandom,
                                 $urandom, $urandom, $urandom, 0);
                2: applyStimulus(1, 1, 2'b10, 0, 3'($urandom), 5'($urandom), $urandom,
                                 $urandom, $urandom, $urandom, 0);
                3: begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                    applyStimulus(1, 1, 2'b01, 0, f3, 5'($urandom), addr, $urandom,
                                  $urandom, $urandom, $urandom_range(0, 3));
                end
                4: begin
                    f3 = 3'($urandom_range(0, 2));
                    applyStimulus(1, 0, 2'($urandom), 1, f3, 5'($urandom), addr, $urandom,
                                  $urandom, $urandom, $urandom_range(0, 3));
                end
                default: applyStimulus(0, 1'($urandom), 2'($urandom), 1'($urandom),
                                       3'($urandom), 5'($urandom), addr, $urandom,
                                       $urandom, $urandom, 0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
